// File: rtl/alu_register_unit.sv
// Operand/result register stage: synchronised execute button drives a
// LATCH/EXEC/HOLD sequence that runs one of 16 ALU operations per press.
module alu_register_unit #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_exec,
   input  logic [3:0] i_sel,
   input  logic [7:0] i_din,
   output logic [7:0] o_reg_a,
   output logic [7:0] o_reg_b,
   output logic [7:0] o_y,
   output logic       o_carry,
   output logic       o_zero,
   output logic       o_busy,
   output logic       o_done
);

   localparam int unsigned W = 8;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SHL  = 4'd2;
   localparam logic [3:0] OP_SHR  = 4'd3;
   localparam logic [3:0] OP_CMP  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_NAND = 4'd8;
   localparam logic [3:0] OP_NOR  = 4'd9;
   localparam logic [3:0] OP_XNOR = 4'd10;
   localparam logic [3:0] OP_INV  = 4'd11;
   localparam logic [3:0] OP_NEG  = 4'd12;
   localparam logic [3:0] OP_STO  = 4'd13;
   localparam logic [3:0] OP_SWP  = 4'd14;
   localparam logic [3:0] OP_LOAD = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_LATCH, S_EXEC, S_HOLD} state_t;

   state_t                 r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_sync, w_rise;

   logic [3:0]   r_op_sel;
   logic [W-1:0] r_op_din, r_op_a, r_op_b;
   logic [W-1:0] r_a, r_b, r_y;
   logic         r_carry, r_zero, r_busy, r_done;

   logic [W:0]   w_res;
   logic         w_upd_y;
   logic [W-1:0] w_a_nxt, w_b_nxt, w_y_nxt;
   logic         w_c_nxt, w_z_nxt, w_busy_nxt, w_done_nxt;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_rise = w_sync & ~r_prev;

   // Button synchroniser and edge-detect history
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_exec};
         r_prev <= w_sync;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_rise) w_state_nxt = S_LATCH;
         S_LATCH: w_state_nxt = S_EXEC;
         S_EXEC:  w_state_nxt = S_HOLD;
         S_HOLD:  if (!w_sync) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Result and next-register values from the captured operands
   always_comb begin
      w_res      = '0;
      w_upd_y    = 1'b1;
      w_a_nxt    = r_a;
      w_b_nxt    = r_b;
      w_y_nxt    = r_y;
      w_c_nxt    = r_carry;
      w_z_nxt    = r_zero;
      case (r_op_sel)
         OP_ADD:  w_res = {1'b0, r_op_a} + {1'b0, r_op_b};
         OP_SUB:  w_res = {1'b0, r_op_a} - {1'b0, r_op_b};
         OP_SHL:  w_res = {r_op_a, 1'b0};
         OP_SHR:  w_res = {r_op_a[0], 1'b0, r_op_a[W-1:1]};
         OP_CMP:  w_res = {(r_op_a < r_op_b),
                           (r_op_a > r_op_b) ? 8'h01 : ((r_op_a == r_op_b) ? 8'h00 : 8'hFF)};
         OP_AND:  w_res = {1'b0, r_op_a & r_op_b};
         OP_OR:   w_res = {1'b0, r_op_a | r_op_b};
         OP_XOR:  w_res = {1'b0, r_op_a ^ r_op_b};
         OP_NAND: w_res = {1'b0, ~(r_op_a & r_op_b)};
         OP_NOR:  w_res = {1'b0, ~(r_op_a | r_op_b)};
         OP_XNOR: w_res = {1'b0, ~(r_op_a ^ r_op_b)};
         OP_INV:  w_res = {1'b0, ~r_op_a};
         OP_NEG:  w_res = {(r_op_a != 8'h00), (~r_op_a) + 8'd1};
         OP_STO: begin
            w_upd_y = 1'b0;
            w_b_nxt = r_y;
         end
         OP_SWP: begin
            w_upd_y = 1'b0;
            w_a_nxt = r_op_b;
            w_b_nxt = r_op_a;
         end
         OP_LOAD: begin
            w_upd_y = 1'b0;
            w_a_nxt = r_op_din;
            w_b_nxt = r_op_a;
         end
         default: w_upd_y = 1'b0;
      endcase
      if (w_upd_y) begin
         w_y_nxt = w_res[W-1:0];
         w_c_nxt = w_res[W];
         w_z_nxt = (w_res[W-1:0] == '0);
      end
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (r_state == S_EXEC);
   end

   // Operand capture in LATCH, architectural write on EXEC exit
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_op_sel <= '0;
         r_op_din <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_y      <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         if (r_state == S_LATCH) begin
            r_op_sel <= i_sel;
            r_op_din <= i_din;
            r_op_a   <= r_a;
            r_op_b   <= r_b;
         end
         if (r_state == S_EXEC) begin
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_y     <= w_y_nxt;
            r_carry <= w_c_nxt;
            r_zero  <= w_z_nxt;
         end
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign o_reg_a = r_a;
   assign o_reg_b = r_b;
   assign o_y     = r_y;
   assign o_carry = r_carry;
   assign o_zero  = r_zero;
   assign o_busy  = r_busy;
   assign o_done  = r_done;

endmodule

// File: tb/tb_alu_register_unit.sv
// Randomised self-checking bench for alu_register_unit against an arithmetic
// reference model of the register file and flags.
module tb_alu_register_unit;

   localparam int unsigned SYNC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       exec;
   logic [3:0] sel;
   logic [7:0] din;
   logic [7:0] reg_a, reg_b, y;
   logic       carry, zero, busy, done;

   int n_chk  = 0;
   int n_pass = 0;

   int m_a, m_b, m_y, m_c, m_z;

   alu_register_unit #(.SYNC_STAGES(SYNC)) dut (
      .i_clock(clk), .i_reset(rst), .i_exec(exec), .i_sel(sel), .i_din(din),
      .o_reg_a(reg_a), .o_reg_b(reg_b), .o_y(y), .o_carry(carry),
      .o_zero(zero), .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_y = 0; m_c = 0; m_z = 1;
   endtask

   task automatic model_op(input int s, input int d);
      int a, b, nxt_a;
      a = m_a; b = m_b;
      if (s <= 12) begin
         case (s)
            0:  begin m_y = (a + b) % 256;       m_c = (a + b) > 255; end
            1:  begin m_y = (a - b + 256) % 256; m_c = a < b; end
            2:  begin m_y = (a * 2) % 256;       m_c = a >= 128; end
            3:  begin m_y = a / 2;               m_c = a % 2; end
            4:  begin m_y = (a > b) ? 1 : ((a == b) ? 0 : 255); m_c = a < b; end
            5:  begin m_y = a & b;         m_c = 0; end
            6:  begin m_y = a | b;         m_c = 0; end
            7:  begin m_y = a ^ b;         m_c = 0; end
            8:  begin m_y = 255 - (a & b); m_c = 0; end
            9:  begin m_y = 255 - (a | b); m_c = 0; end
            10: begin m_y = 255 - (a ^ b); m_c = 0; end
            11: begin m_y = 255 - a;       m_c = 0; end
            default: begin m_y = (256 - a) % 256; m_c = a != 0; end
         endcase
         m_z = (m_y == 0);
      end else if (s == 13) begin
         m_b = m_y;
      end else if (s == 14) begin
         m_a = b; m_b = a;
      end else begin
         nxt_a = d;
         m_b = a; m_a = nxt_a;
      end
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".a"},     int'(reg_a), m_a);
      chk({tag, ".b"},     int'(reg_b), m_b);
      chk({tag, ".y"},     int'(y),     m_y);
      chk({tag, ".carry"}, int'(carry), m_c);
      chk({tag, ".zero"},  int'(zero),  m_z);
   endtask

   // One full press: check latency, single done pulse, busy span and release timing
   task automatic run_op(input string tag, input int s, input int d, input int hold,
                         input bit scramble);
      int k, kb, kd, nd, rel;
      bit gap;
      @(negedge clk);
      sel = 4'(s); din = 8'(d); exec = 1'b1;
      model_op(s, d);
      k = 0; kb = -1; kd = -1; nd = 0; gap = 1'b0;
      while (k < 200 && !(kd >= 0 && k >= kd + hold)) begin
         @(negedge clk);
         k++;
         if (busy && kb < 0) kb = k;
         if (kb > 0 && !busy) gap = 1'b1;
         if (scramble && kb > 0 && k == kb + 1) begin
            sel = 4'($urandom); din = 8'($urandom);
         end
         if (done) begin
            nd++;
            if (kd < 0) begin
               kd = k;
               check_regs(tag);
            end
         end
      end
      chk({tag, ".latency"}, kd, int'(SYNC) + 3);
      chk({tag, ".busy_span"}, int'(gap), 0);
      exec = 1'b0;
      rel = 0;
      while (rel < 20 && busy) begin
         @(negedge clk);
         rel++;
         if (done) nd++;
      end
      chk({tag, ".release"}, rel, int'(SYNC) + 1);
      chk({tag, ".done_pulses"}, nd, 1);
   endtask

   // Start an operation, then assert reset while it sits in EXEC
   task automatic abort_op(input int s);
      int k, kb, nd;
      @(negedge clk);
      sel = 4'(s); din = 8'h00; exec = 1'b1;
      k = 0; kb = -1; nd = 0;
      while (k < 30 && !(kb > 0 && k == kb + 1)) begin
         @(negedge clk);
         k++;
         if (busy && kb < 0) kb = k;
         if (done) nd++;
      end
      chk("abort.in_exec", k, int'(SYNC) + 2);
      rst = 1'b1;
      #1;
      model_reset();
      check_regs("abort");
      chk("abort.busy", int'(busy), 0);
      repeat (3) begin
         @(negedge clk);
         if (done) nd++;
      end
      exec = 1'b0;
      rst = 1'b0;
      repeat (int'(SYNC) + 4) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort.no_done", nd, 0);
      check_regs("abort.after");
   endtask

   initial begin
      int s, d;
      rst = 1'b1; exec = 1'b0; sel = 4'h0; din = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      check_regs("reset");
      chk("reset.busy", int'(busy), 0);
      chk("reset.done", int'(done), 0);
      rst = 1'b0;
      @(negedge clk);

      run_op("load7", 15, 8'h07, 1, 1'b0);
      abort_op(0);

      run_op("load5", 15, 8'h05, 2, 1'b0);
      run_op("load3", 15, 8'h03, 0, 1'b0);
      chk("load.a_const", int'(reg_a), 8'h03);
      chk("load.b_const", int'(reg_b), 8'h05);
      run_op("add_hold50", 0, 0, 50, 1'b0);
      chk("add.y_const", int'(y), 8'h08);
      run_op("sub", 1, 0, 1, 1'b0);
      chk("sub.y_const", int'(y), 8'hFE);
      run_op("cmp", 4, 0, 1, 1'b0);
      chk("cmp.y_const", int'(y), 8'hFF);
      run_op("add2", 0, 0, 1, 1'b0);
      run_op("sto_scr", 13, 0, 1, 1'b1);
      chk("sto.b_const", int'(reg_b), 8'h08);
      run_op("swp", 14, 0, 1, 1'b0);
      chk("swp.y_const", int'(y), 8'h08);

      run_op("load01", 15, 8'h01, 0, 1'b0);
      run_op("loadff", 15, 8'hFF, 0, 1'b0);
      run_op("add_wrap", 0, 0, 1, 1'b1);
      chk("add_wrap.c_const", int'(carry), 1);
      run_op("shl", 2, 0, 1, 1'b0);
      run_op("load00", 15, 8'h00, 0, 1'b0);
      run_op("neg0", 12, 0, 1, 1'b0);
      chk("neg0.z_const", int'(zero), 1);

      for (int i = 0; i < 40; i++) begin
         s = int'($urandom_range(0, 15));
         d = int'($urandom_range(0, 255));
         run_op($sformatf("rnd%0d_op%0d", i, s), s, d, int'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_register_unit.md
Name: alu_register_unit

Overview:
- Operand/result register stage that sits directly upstream of the result muxes and the seven-segment display path.
- Holds operand registers A and B and a result register Y.
- Executes one of 16 operations, selected by sel, once per rising edge of a synchronised execute input.
- Drives reg_a, reg_b and y to the display/mux logic, plus status flags.

Parameters:
- SYNC_STAGES, 2, number of flip-flops synchronising exec; minimum 2.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state
- exec  input  1  asynchronous level from a button; each rising edge requests one operation
- sel  input  4  operation code, sampled in LATCH
- din  input  8  switch data, sampled in LATCH (used by LOAD)
- reg_a  output  8  register A
- reg_b  output  8  register B
- y  output  8  result register
- carry  output  1  carry/borrow flag
- zero  output  1  result-zero flag
- busy  output  1  high while not in IDLE
- done  output  1  one-cycle pulse marking completion of an operation

Behaviour:
- Reset (asynchronous, active-high):
  - reg_a, reg_b, y = 8'h00; carry = 0; zero = 1; busy = 0; done = 0.
  - State = IDLE; synchroniser and edge-detect flops = 0.
  - Reset asserted in any state, including mid-EXEC, aborts the operation; no partial register write survives.
- exec passes through SYNC_STAGES flops. A rising edge is a synchronised 1 with the previous sample 0. A rising edge is acted on only in IDLE; edges in any other state are ignored.
- State machine, one cycle per state except HOLD:
  - IDLE -> LATCH on rising edge.
  - LATCH: capture sel, din, A, B into internal operand registers -> EXEC.
  - EXEC: compute from the captured values; write destination registers and flags on the exit edge -> HOLD.
  - HOLD: stay while synchronised exec = 1; -> IDLE when it is 0.
- Timing:
  - busy = 1 in LATCH, EXEC and HOLD.
  - done = 1 for exactly the first HOLD cycle, the same cycle the updated values first appear on the outputs.
  - Latency from the synchronised edge to updated outputs: 3 clocks.
- Operations (A, B are captured values; all arithmetic is 8-bit unsigned, 9-bit internally for carry):
  - 0 ADD: Y = A+B; carry = bit 8.
  - 1 SUB: Y = A-B mod 256; carry = (A < B) (borrow).
  - 2 SHL: Y = A<<1; carry = A[7].
  - 3 SHR: Y = A>>1 (logical); carry = A[0].
  - 4 CMP: Y = 8'h01 if A > B, 8'h00 if equal, 8'hFF if A < B; carry = (A < B).
  - 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR, 10 XNOR: Y = bitwise A op B; carry = 0.
  - 11 INV: Y = ~A; carry = 0.
  - 12 NEG: Y = (~A)+1; carry = (A != 0).
  - 13 STO: B = Y. Y, carry and zero are unchanged.
  - 14 SWP: A = B and B = A, simultaneously. Y and flags are unchanged.
  - 15 LOAD: B = A, A = din, simultaneously (two LOADs load both operands). Y and flags are unchanged.
- Flag rules:
  - For ops 0-12, zero = (new Y == 0).
  - A and B are modified only by STO, SWP and LOAD.
- Boundary conditions:
  - exec held high for many cycles: exactly one operation.
  - exec toggling during LATCH or EXEC: ignored.
  - exec glitch shorter than one clock: may or may not register, but never causes more than one operation.
  - sel and din changes after LATCH do not affect the running operation.

Test Plan:
- Reset -> reg_a = reg_b = y = 00, zero = 1, carry = 0, busy = 0; assert reset during EXEC of ADD -> all outputs return to the reset values, done never pulses.
- LOAD din = 05, then LOAD din = 03 -> after the second operation A = 03, B = 05; y = 00 and zero = 1 unchanged.
- With A = 03, B = 05: ADD -> y = 08, carry = 0, zero = 0; SUB -> y = FE, carry = 1; CMP -> y = FF, carry = 1.
- A = FF, B = 01: ADD -> y = 00, carry = 1, zero = 1. SHL -> y = FE, carry = 1. NEG with A = 00 -> y = 00, carry = 0, zero = 1.
- exec held high for 50 cycles with sel = ADD -> exactly one done pulse; y updated once. Measured from the synchronised edge, busy stays high until 1 cycle after exec is released.
- STO after y = 08 -> B = 08; SWP -> A and B exchanged; y = 08 retained. Changing sel in the EXEC cycle does not alter the result.
